// File: rtl/alu_iter.sv
// Iterative 32-bit ALU: single-cycle logic/arith/shift ops, plus signed mul and div
// computed one bit per cycle on magnitudes, with the signs applied in a final FIX cycle.
module alu_iter (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  control_in,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  shamt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic [31:0] hi,
  output logic        zero,
  output logic        overflow,
  output logic        div_zero,
  output logic        illegal
);

  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [32:0] acc_q, acc_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] dvs_q, dvs_d;
  logic        qneg_q, qneg_d, rneg_q, rneg_d, is_div_q, is_div_d;
  logic [31:0] result_q, result_d, hi_q, hi_d;
  logic        zero_q, zero_d, ovf_q, ovf_d, dz_q, dz_d, ill_q, ill_d;

  logic [31:0] abs_a, abs_b, sum, diff, alu_res;
  logic        alu_ovf, alu_ill;
  logic        accept;
  logic [32:0] mul_add, div_shift;
  logic [63:0] prod, prod_s;
  logic [31:0] quo_s, rem_s;

  assign in_ready  = (state_q == IDLE) && !reset;
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid && in_ready;

  assign abs_a = a[31] ? (~a + 32'd1) : a;
  assign abs_b = b[31] ? (~b + 32'd1) : b;
  assign sum   = a + b;
  assign diff  = a - b;

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_ill = 1'b0;
    case (control_in)
      4'd0:  alu_res = a & b;
      4'd1:  alu_res = a | b;
      4'd2: begin
        alu_res = sum;
        alu_ovf = (a[31] == b[31]) && (sum[31] != a[31]);
      end
      4'd4, 4'd5: alu_res = '0;
      4'd6: begin
        alu_res = diff;
        alu_ovf = (a[31] == ~b[31]) && (diff[31] != a[31]);
      end
      4'd7:  alu_res = {31'd0, $signed(a) < $signed(b)};
      4'd8:  alu_res = b << shamt;
      4'd9:  alu_res = b >> shamt;
      4'd10: alu_res = a ^ b;
      4'd11: alu_res = ~(a | b);
      4'd12: alu_res = $unsigned($signed(b) >>> shamt);
      default: alu_ill = 1'b1;
    endcase
  end

  // Datapath steps: mul shifts {acc,lo} right after a conditional add;
  // div shifts the dividend out of lo into the partial remainder in acc.
  assign mul_add   = {1'b0, acc_q[31:0]} + (lo_q[0] ? {1'b0, dvs_q} : 33'd0);
  assign div_shift = {acc_q[31:0], lo_q[31]};
  assign prod      = {acc_q[31:0], lo_q};
  assign prod_s    = qneg_q ? (~prod + 64'd1) : prod;
  assign quo_s     = qneg_q ? (~lo_q + 32'd1) : lo_q;
  assign rem_s     = rneg_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    lo_d     = lo_q;
    dvs_d    = dvs_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    is_div_d = is_div_q;
    result_d = result_q;
    hi_d     = hi_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    dz_d     = dz_q;
    ill_d    = ill_q;
    case (state_q)
      IDLE: if (accept) begin
        if ((control_in == 4'd5) || (control_in == 4'd4 && b != 32'd0)) begin
          state_d  = (control_in == 4'd5) ? MUL : DIV;
          cnt_d    = 6'd32;
          acc_d    = '0;
          lo_d     = abs_a;
          dvs_d    = abs_b;
          qneg_d   = a[31] ^ b[31];
          rneg_d   = a[31];
          is_div_d = (control_in == 4'd4);
        end else if (control_in == 4'd4) begin
          state_d  = DONE;
          result_d = 32'hFFFF_FFFF;
          hi_d     = a;
          zero_d   = 1'b0;
          ovf_d    = 1'b0;
          dz_d     = 1'b1;
          ill_d    = 1'b0;
        end else begin
          state_d  = DONE;
          result_d = alu_res;
          hi_d     = '0;
          zero_d   = (alu_res == 32'd0);
          ovf_d    = alu_ovf;
          dz_d     = 1'b0;
          ill_d    = alu_ill;
        end
      end
      MUL: begin
        acc_d = {1'b0, mul_add[32:1]};
        lo_d  = {mul_add[0], lo_q[31:1]};
        cnt_d = cnt_q - 6'd1;
        if (cnt_q == 6'd1) state_d = FIX;
      end
      DIV: begin
        if (div_shift >= {1'b0, dvs_q}) begin
          acc_d = div_shift - {1'b0, dvs_q};
          lo_d  = {lo_q[30:0], 1'b1};
        end else begin
          acc_d = div_shift;
          lo_d  = {lo_q[30:0], 1'b0};
        end
        cnt_d = cnt_q - 6'd1;
        if (cnt_q == 6'd1) state_d = FIX;
      end
      FIX: begin
        state_d  = DONE;
        result_d = is_div_q ? quo_s : prod_s[31:0];
        hi_d     = is_div_q ? rem_s : prod_s[63:32];
        zero_d   = is_div_q ? (quo_s == 32'd0) : (prod_s[31:0] == 32'd0);
        ovf_d    = 1'b0;
        dz_d     = 1'b0;
        ill_d    = 1'b0;
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      lo_q     <= '0;
      dvs_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      is_div_q <= 1'b0;
      result_q <= '0;
      hi_q     <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      dz_q     <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      lo_q     <= lo_d;
      dvs_q    <= dvs_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      is_div_q <= is_div_d;
      result_q <= result_d;
      hi_q     <= hi_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      dz_q     <= dz_d;
      ill_q    <= ill_d;
    end
  end

  assign result   = result_q;
  assign hi       = hi_q;
  assign zero     = zero_q;
  assign overflow = ovf_q;
  assign div_zero = dz_q;
  assign illegal  = ill_q;

endmodule

// File: doc/alu_iter.md
ALU_ITER -- requirements
Module: alu_iter

Interface
REQ-001 The block SHALL have the port `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port `reset`, input, 1 bit: asynchronous, active-high reset; clears all state immediately, independent of `clk`.
REQ-003 The block SHALL have the port `in_valid`, input, 1 bit: an operation is presented.
REQ-004 The block SHALL have the port `in_ready`, output, 1 bit: the block accepts an operation this cycle.
REQ-005 The block SHALL have the port `control_in`, input, 4 bits: the ALU control code produced by the ALU control decoder.
REQ-006 The block SHALL have the ports `a` and `b`, input, 32 bits each: the operands (rs and rt).
REQ-007 The block SHALL have the port `shamt`, input, 5 bits: the shift amount for shift operations.
REQ-008 The block SHALL have the port `out_valid`, output, 1 bit: the result is available.
REQ-009 The block SHALL have the port `out_ready`, input, 1 bit: the consumer takes the result.
REQ-010 The block SHALL have the port `result`, output, 32 bits: the primary result (LO for mul/div).
REQ-011 The block SHALL have the port `hi`, output, 32 bits: the upper product for mul, the remainder for div, and 0 for all other operations.
REQ-012 The block SHALL have the port `zero`, output, 1 bit: `result` == 0.
REQ-013 The block SHALL have the port `overflow`, output, 1 bit: signed overflow on add/sub; 0 for all other operations.
REQ-014 The block SHALL have the port `div_zero`, output, 1 bit: div with `b` == 0.
REQ-015 The block SHALL have the port `illegal`, output, 1 bit: the accepted code is 3, 13, 14 or 15.

Function
REQ-016 Accept SHALL occur on the rising edge where `in_valid` && `in_ready`; `control_in`, `a`, `b` and `shamt` SHALL be captured at accept, and later changes to them SHALL be ignored.
REQ-017 `in_ready` SHALL equal (state == IDLE).
REQ-018 Code map SHALL be: 0 and, 1 or, 2 add, 4 div, 5 mul, 6 sub, 7 slt (signed, result 0 or 1), 8 sll, 9 srl, 10 xor, 11 nor, 12 sra.
REQ-019 Shifts SHALL operate on `b` by `shamt`: sll/srl fill with zeros, and sra replicates b[31].
REQ-020 add/sub SHALL wrap modulo 2^32; `overflow` = operand signs (after negation of b for sub) equal AND result sign differs.
REQ-021 The FSM states SHALL be IDLE, MUL, DIV, FIX, DONE.
REQ-022 IDLE SHALL transition to DONE on accepting a single-cycle op (codes other than 4/5, including illegal), with `out_valid` asserted in the cycle after accept (latency 1).
REQ-023 IDLE SHALL transition to MUL on accepting code 5; absolute values of `a` and `b` SHALL be loaded, a 6-bit counter SHALL be set to 32, and MUL SHALL perform one shift-add step per cycle.
REQ-024 IDLE SHALL transition to DIV on accepting code 4 with `b` != 0; DIV SHALL perform restoring division on magnitudes, one quotient bit per cycle, for 32 cycles.
REQ-025 On accepting code 4 with `b` == 0, IDLE SHALL transition directly to DONE with `result` = 32'hFFFFFFFF, `hi` = `a`, and `div_zero` = 1.
REQ-026 MUL and DIV SHALL transition to FIX when the counter reaches 0; FIX SHALL apply the signs (1 cycle), then transition to DONE.
REQ-027 Mul/div latency SHALL be exactly 34 cycles from the accept edge to the first cycle `out_valid` is high.
REQ-028 mul SHALL be signed: the 64-bit product = {`hi`,`result`}, negated if a[31]^b[31].
REQ-029 div SHALL be signed: quotient sign = a[31]^b[31]; remainder sign = a[31].
REQ-030 For div, 0x80000000 / -1 SHALL yield `result` = 0x80000000, `hi` = 0, with no flag.
REQ-031 DONE SHALL hold `out_valid` = 1 with all outputs stable until `out_ready`; on `out_valid` && `out_ready` the FSM SHALL transition to IDLE.
REQ-032 A new accept SHALL NOT occur in the same cycle as result handoff; the minimum issue interval SHALL therefore be 2 cycles.
REQ-033 Illegal codes SHALL produce `result` = 0, `hi` = 0, `illegal` = 1, and `zero` = 1.
REQ-034 `zero`, `overflow`, `div_zero` and `illegal` SHALL be registered with `result` and be valid only while `out_valid` = 1.

Reset
REQ-035 Reset assertion SHALL set the state to IDLE, `out_valid` to 0, `in_ready` to 1 (after reset is released), and `result`, `hi`, all flags and the counter to 0.
REQ-036 Reset mid-MUL/DIV SHALL abandon the operation with no `out_valid` pulse; the first accept after release SHALL start clean.
REQ-037 `in_ready` SHALL be 0 while `reset` is high.

Verification
REQ-038 The bench SHALL cover: add 0x7FFFFFFF + 1 -> `result` 0x80000000, `overflow` 1, `out_valid` 1 cycle after accept; sub 5 - 5 -> `zero` 1.
REQ-039 The bench SHALL cover: mul -3 x 7 -> {`hi`,`result`} = 0xFFFFFFFF_FFFFFFEB, `out_valid` exactly 34 cycles after accept, `in_ready` 0 throughout.
REQ-040 The bench SHALL cover: div -7 / 2 -> `result` 0xFFFFFFFD, `hi` 0xFFFFFFFF; div 9 / 0 -> `result` 0xFFFFFFFF, `hi` 9, `div_zero` 1, latency 1.
REQ-041 The bench SHALL cover: sra `b` = 0x80000000, `shamt` 4 -> 0xF8000000; srl the same -> 0x08000000; slt -1 < 1 -> 1.
REQ-042 The bench SHALL cover: hold `out_ready` = 0 for 10 cycles after a result -> outputs stable, `in_ready` 0; then `out_ready` 1 -> IDLE next cycle.
REQ-043 The bench SHALL cover: assert `reset` 10 cycles into a div -> `out_valid` never pulses; then an and of 0xF0F0 & 0xFF00 -> `result` 0xF000.
